access_lock_ctrl: RTL
=====================

Name: access_lock_ctrl

Overview:
- Downstream stage of the password checker FSM. It consumes the checker's pass_ok plus an end-of-attempt strobe from the keypad front end.
- Decides each attempt: success opens the door for a fixed time; repeated failures trigger a timed lockout with an alarm pulse.
- Drives input_allow back to the keypad/checker so key entry is ignored while the door is open or the block is locked out.

Parameters:
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..2^FAIL_W-1)
UNLOCK_CYCLES, 50, clock cycles unlock stays high (>=1, < 2^CNT_W)
LOCKOUT_CYCLES, 200, clock cycles locked_out stays high (>=1, < 2^CNT_W)
CNT_W, 16, width of the internal down-timer
FAIL_W, 4, width of fail_count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (asserted when 0), one clock domain
pass_ok  input  1  from password checker; high while correct password recognised
attempt_end  input  1  single-cycle strobe: user finished an attempt (enter key)
unlock  output  1  door release, high for exactly UNLOCK_CYCLES cycles
locked_out  output  1  high for exactly LOCKOUT_CYCLES cycles during lockout
alarm  output  1  single-cycle pulse on lockout entry
input_allow  output  1  high only in IDLE; gates checker enable upstream
fail_count  output  FAIL_W  consecutive failures so far

Behaviour:
- All outputs are registered or decoded directly from flops. There is no combinational path from inputs to outputs.
- Reset (reset==0, asynchronous): state=IDLE, timer=0, ok_seen=0, fail_count=0, unlock=0, locked_out=0, alarm=0, input_allow=1. A mid-operation reset aborts UNLOCKED or LOCKOUT immediately.
- States: IDLE, UNLOCKED, LOCKOUT.
- IDLE:
  - pass_ok==1 sets the sticky flag ok_seen.
  - On attempt_end sampled at edge N, success = ok_seen | pass_ok (a same-cycle pass_ok counts).
  - Success: at edge N go to UNLOCKED, timer=UNLOCK_CYCLES-1, fail_count=0, ok_seen=0.
  - Failure with fail_count+1 < MAX_FAILS: stay IDLE, fail_count+1, ok_seen=0.
  - Failure with fail_count+1 == MAX_FAILS: go to LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_count=MAX_FAILS, alarm=1 for exactly the cycle after edge N.
  - pass_ok without attempt_end never unlocks.
- UNLOCKED:
  - unlock=1, input_allow=0.
  - Timer decrements each cycle. When timer==0, go to IDLE at the next edge. Total unlock width = UNLOCK_CYCLES.
- LOCKOUT:
  - locked_out=1, input_allow=0.
  - Timer decrements each cycle. When timer==0, go to IDLE and clear fail_count=0. Total width = LOCKOUT_CYCLES.
- pass_ok and attempt_end are ignored in UNLOCKED and LOCKOUT. ok_seen is held at 0 there, so a pass_ok during lockout does not carry over.
- Latency: output change is visible the cycle after the edge that samples attempt_end (1 cycle).
- fail_count saturates at MAX_FAILS and never wraps. Timer never underflows; the state exits at 0.
- input_allow rises in the cycle immediately after leaving UNLOCKED or LOCKOUT. An attempt_end in that first IDLE cycle is processed normally.

Test Plan:
(Bench parameters: MAX_FAILS=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8.)
1. Reset: hold reset=0 for 3 cycles, then release -> unlock=0, locked_out=0, alarm=0, fail_count=0, input_allow=1. Assert reset=0 asynchronously between edges -> outputs return to these values without waiting for a clock edge.
2. Success: pulse pass_ok for 1 cycle, then attempt_end 2 cycles later -> unlock=1 for exactly 4 cycles, input_allow=0 for the same 4 cycles, fail_count stays 0. Also apply pass_ok and attempt_end in the same cycle -> same result.
3. Lockout: three attempt_end pulses with pass_ok=0 -> fail_count 1, 2, then alarm=1 for one cycle and locked_out=1 for 8 cycles. Afterwards fail_count=0 and input_allow=1.
4. Failure reset by success: two failed attempts (fail_count=2), then a successful attempt -> unlock pulse of 4 cycles, fail_count=0. A subsequent failure gives fail_count=1, not lockout.
5. Ignore while busy: during UNLOCKED and LOCKOUT, drive pass_ok=1 and attempt_end pulses -> no timer extension and fail_count unchanged. A bare attempt_end in the first IDLE cycle afterwards counts as a failure (fail_count=1).
6. Reset mid-LOCKOUT (cycle 3 of 8) -> immediately locked_out=0, fail_count=0, input_allow=1, and no alarm pulse after release.

Source files
------------

// File: rtl/access_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : access_lock_ctrl
//  Description : Attempt arbiter behind the password checker. A successful
//                attempt opens the door for a fixed time. Repeated failures
//                trigger a timed lockout with a one-cycle alarm pulse. Key
//                entry is gated off while the door is open or locked out.
//  Revision    : 1.0 - initial release
// ============================================================================
module access_lock_ctrl #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 50,
  parameter int unsigned LOCKOUT_CYCLES = 200,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned FAIL_W         = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pass_ok,
  input  logic              attempt_end,
  output logic              unlock,
  output logic              locked_out,
  output logic              alarm,
  output logic              input_allow,
  output logic [FAIL_W-1:0] fail_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_UNLOCKED = 2'd1;
  localparam logic [1:0] S_LOCKOUT  = 2'd2;

  // Timer loads are one less than the width because the exit happens on the
  // edge where the timer already reads zero.
  localparam logic [CNT_W-1:0]  c_unlock_load  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_lockout_load = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] c_max_fails    = FAIL_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0]  c_timer_one    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FAIL_W:0]   c_fail_one     = {{FAIL_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_timer;
  logic              r_ok_seen;
  logic [FAIL_W-1:0] r_fail_count;
  logic              r_alarm;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_timer_nxt;
  logic              w_ok_seen_nxt;
  logic [FAIL_W-1:0] w_fail_count_nxt;
  logic              w_alarm_nxt;
  logic [FAIL_W:0]   w_fail_inc;
  logic              w_success;
  logic              w_timer_zero;

  // One extra bit so the increment can never wrap before the compare.
  assign w_fail_inc   = {1'b0, r_fail_count} + c_fail_one;
  // A pass_ok arriving in the same cycle as attempt_end still counts.
  assign w_success    = r_ok_seen | pass_ok;
  assign w_timer_zero = (r_timer == '0);

  // Next-state, timer, failure counter and alarm decision.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_ok_seen_nxt    = r_ok_seen;
    w_fail_count_nxt = r_fail_count;
    w_alarm_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (attempt_end) begin
          w_ok_seen_nxt = 1'b0;
          if (w_success) begin
            w_state_nxt      = S_UNLOCKED;
            w_timer_nxt      = c_unlock_load;
            w_fail_count_nxt = '0;
          end else if (w_fail_inc >= {1'b0, c_max_fails}) begin
            w_state_nxt      = S_LOCKOUT;
            w_timer_nxt      = c_lockout_load;
            w_fail_count_nxt = c_max_fails;
            w_alarm_nxt      = 1'b1;
          end else begin
            w_fail_count_nxt = w_fail_inc[FAIL_W-1:0];
          end
        end else if (pass_ok) begin
          w_ok_seen_nxt = 1'b1;
        end
      end
      S_UNLOCKED: begin
        // Inputs are ignored and no recognition carries over into IDLE.
        w_ok_seen_nxt = 1'b0;
        if (w_timer_zero) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
        end
      end
      S_LOCKOUT: begin
        w_ok_seen_nxt = 1'b0;
        if (w_timer_zero) begin
          w_state_nxt      = S_IDLE;
          w_fail_count_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_timer_nxt      = '0;
        w_ok_seen_nxt    = 1'b0;
        w_fail_count_nxt = '0;
      end
    endcase
  end

  // State registers with asynchronous abort back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_ok_seen    <= 1'b0;
      r_fail_count <= '0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_ok_seen    <= w_ok_seen_nxt;
      r_fail_count <= w_fail_count_nxt;
      r_alarm      <= w_alarm_nxt;
    end
  end

  // Outputs are pure decodes of flops; no input reaches them combinationally.
  assign unlock      = (r_state == S_UNLOCKED);
  assign locked_out  = (r_state == S_LOCKOUT);
  assign input_allow = (r_state == S_IDLE);
  assign alarm       = r_alarm;
  assign fail_count  = r_fail_count;

endmodule
`default_nettype wire
